abus_cs_seq: RTL and testbench

// - Bus-cycle chip-select sequencer on the address bus, directly downstream of the wide address-match NAND.
// - Samples the active-low match (matchl) when a cycle starts.
// - On a hit, drives active-low chip, output and write enables for a programmed number of wait states, then returns ack.
// - On a miss, stays idle so another decoder can claim the cycle.

---
 rtl/abus_pkg.sv | 17 +
 rtl/abus_ws_cnt.sv | 32 +++
 rtl/abus_cs_seq.sv | 113 +++++++++++
 tb/tb_abus_cs_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/abus_pkg.sv
// Shared types and constants for the address-bus chip-select sequencer.
// States, default wait-state width and strobe polarities.
package abus_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam int   WS_DEFAULT = 4;

   localparam logic STB_ON  = 1'b0;
   localparam logic STB_OFF = 1'b1;

endpackage

// File: rtl/abus_ws_cnt.sv
// Loadable wait-state down-counter with zero flag.
// Decrement saturates at zero so the count never wraps.
module abus_ws_cnt
   import abus_pkg::*;
#(
   parameter int W = WS_DEFAULT
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   input  logic         i_dec,
   output logic [W-1:0] o_cnt,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/abus_cs_seq.sv
// Bus-cycle chip-select sequencer fed by the address-match NAND.
// Claims matching cycles and drives registered active-low strobes and ack.
module abus_cs_seq
   import abus_pkg::*;
#(
   parameter int WSW  = WS_DEFAULT,
   parameter int HOLD = 1
) (
   input  logic           sys_clk,
   input  logic           resetl,
   input  logic           matchl,
   input  logic           start,
   input  logic           rw,
   input  logic [WSW-1:0] ws,
   input  logic           abortl,
   output logic           csl,
   output logic           oel,
   output logic           wel,
   output logic           ack,
   output logic           busy
);

   localparam logic [1:0] HOLD_LD = (HOLD > 0) ? 2'(HOLD - 1) : 2'd0;

   state_t         r_state;
   logic           r_rw;
   logic [1:0]     r_hold;
   logic [WSW-1:0] w_cnt;
   logic           w_zero;
   logic           w_one;
   logic           w_load;
   logic           w_dec;

   assign w_load = (r_state == S_IDLE) && start && !matchl;
   assign w_dec  = (r_state == S_STROBE) && abortl;
   assign w_one  = (w_cnt == WSW'(1));

   abus_ws_cnt #(.W(WSW)) u_cnt (
      .i_clk   (sys_clk),
      .i_rst_n (resetl),
      .i_load  (w_load),
      .i_val   (ws),
      .i_dec   (w_dec),
      .o_cnt   (w_cnt),
      .o_zero  (w_zero)
   );

   // Outputs are loaded with the values of the state being entered.
   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         r_state <= S_IDLE;
         r_rw    <= 1'b0;
         r_hold  <= 2'd0;
         csl     <= STB_OFF;
         oel     <= STB_OFF;
         wel     <= STB_OFF;
         ack     <= 1'b0;
         busy    <= 1'b0;
      end else if ((r_state != S_IDLE) && !abortl) begin
         r_state <= S_IDLE;
         csl     <= STB_OFF;
         oel     <= STB_OFF;
         wel     <= STB_OFF;
         ack     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start && !matchl) begin
                  r_state <= S_SETUP;
                  r_rw    <= rw;
                  csl     <= STB_ON;
                  busy    <= 1'b1;
               end
            end
            S_SETUP: begin
               r_state <= S_STROBE;
               oel     <= r_rw ? STB_ON : STB_OFF;
               wel     <= r_rw ? STB_OFF : STB_ON;
               ack     <= w_zero;
            end
            S_STROBE: begin
               if (!w_zero) begin
                  ack <= w_one;
               end else begin
                  ack <= 1'b0;
                  oel <= STB_OFF;
                  wel <= STB_OFF;
                  if (HOLD == 0) begin
                     r_state <= S_IDLE;
                     csl     <= STB_OFF;
                     busy    <= 1'b0;
                  end else begin
                     r_state <= S_HOLD;
                     r_hold  <= HOLD_LD;
                  end
               end
            end
            S_HOLD: begin
               if (r_hold == 2'd0) begin
                  r_state <= S_IDLE;
                  csl     <= STB_OFF;
                  busy    <= 1'b0;
               end else begin
                  r_hold <= r_hold - 2'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_abus_cs_seq.sv
// Directed bench for abus_cs_seq: two instances (HOLD=1, HOLD=3) share stimulus.
// Expected ack cycles are queued at issue and popped when ack appears.
module tb_abus_cs_seq;

   logic       clk;
   logic       resetl;
   logic       matchl;
   logic       start;
   logic       rw_i;
   logic [3:0] ws_i;
   logic       abortl;
   logic       csl, oel, wel, ack, busy;
   logic       csl3, oel3, wel3, ack3, busy3;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int q_a[$];
   int q_b[$];

   abus_cs_seq #(.WSW(4), .HOLD(1)) u_dut (
      .sys_clk (clk),
      .resetl  (resetl),
      .matchl  (matchl),
      .start   (start),
      .rw      (rw_i),
      .ws      (ws_i),
      .abortl  (abortl),
      .csl     (csl),
      .oel     (oel),
      .wel     (wel),
      .ack     (ack),
      .busy    (busy)
   );

   abus_cs_seq #(.WSW(4), .HOLD(3)) u_dut3 (
      .sys_clk (clk),
      .resetl  (resetl),
      .matchl  (matchl),
      .start   (start),
      .rw      (rw_i),
      .ws      (ws_i),
      .abortl  (abortl),
      .csl     (csl3),
      .oel     (oel3),
      .wel     (wel3),
      .ack     (ack3),
      .busy    (busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (resetl === 1'b1 && ack === 1'b1) begin
         if (q_a.size() == 0) chk1("ack_h1_unexpected", ack, 1'b0);
         else chkn("ack_h1_cycle", cyc, q_a.pop_front());
      end
      if (resetl === 1'b1 && ack3 === 1'b1) begin
         if (q_b.size() == 0) chk1("ack_h3_unexpected", ack3, 1'b0);
         else chkn("ack_h3_cycle", cyc, q_b.pop_front());
      end
   end

   function automatic bit f_act(int k, bit hit, int w, int hold, int ab);
      return hit && k >= 1 && k <= 2 + w + hold && (ab < 0 || k <= ab);
   endfunction

   function automatic bit f_stb(int k, bit hit, int w, int ab);
      return hit && k >= 2 && k <= 2 + w && (ab < 0 || k <= ab);
   endfunction

   // ab: abort asserted during that cycle offset; sk: extra start at that offset.
   task automatic run(input string nm, input bit hit, input bit rd,
                      input int w, input int ab, input int sk, input int n);
      int  c0;
      int  k;
      bit  a1, a3, s1, s3;
      chk1({nm, "_idle_h1"}, busy, 1'b0);
      chk1({nm, "_idle_h3"}, busy3, 1'b0);
      matchl = !hit;
      rw_i   = rd;
      ws_i   = 4'(w);
      start  = 1'b1;
      c0     = cyc;
      if (hit && (ab < 0 || ab >= 2 + w)) begin
         q_a.push_back(c0 + 2 + w);
         q_b.push_back(c0 + 2 + w);
      end
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         k  = cyc - c0;
         a1 = f_act(k, hit, w, 1, ab);
         a3 = f_act(k, hit, w, 3, ab);
         s1 = f_stb(k, hit, w, ab);
         s3 = s1;
         chk1($sformatf("%s_k%0d_csl", nm, k), csl, !a1);
         chk1($sformatf("%s_k%0d_busy", nm, k), busy, a1);
         chk1($sformatf("%s_k%0d_oel", nm, k), oel, !(s1 && rd));
         chk1($sformatf("%s_k%0d_wel", nm, k), wel, !(s1 && !rd));
         chk1($sformatf("%s_k%0d_csl3", nm, k), csl3, !a3);
         chk1($sformatf("%s_k%0d_busy3", nm, k), busy3, a3);
         chk1($sformatf("%s_k%0d_oel3", nm, k), oel3, !(s3 && rd));
         chk1($sformatf("%s_k%0d_wel3", nm, k), wel3, !(s3 && !rd));
         start  = (k == sk);
         matchl = (k == sk) ? 1'b0 : 1'b1;
         abortl = (k == ab) ? 1'b0 : 1'b1;
      end
      start  = 1'b0;
      abortl = 1'b1;
      matchl = 1'b1;
      chkn({nm, "_ack_pending_h1"}, q_a.size(), 0);
      chkn({nm, "_ack_pending_h3"}, q_b.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      resetl = 1'b0;
      matchl = 1'b1;
      start  = 1'b0;
      rw_i   = 1'b0;
      ws_i   = 4'd0;
      abortl = 1'b1;
      repeat (3) @(negedge clk);
      chk1("rst_csl", csl, 1'b1);
      chk1("rst_oel", oel, 1'b1);
      chk1("rst_wel", wel, 1'b1);
      chk1("rst_ack", ack, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_csl3", csl3, 1'b1);
      resetl = 1'b1;
      @(negedge clk);

      run("rd_ws3", 1'b1, 1'b1, 3, -1, -1, 10);
      run("wr_ws0", 1'b1, 1'b0, 0, -1, -1, 8);
      run("miss", 1'b0, 1'b1, 5, -1, -1, 10);
      run("abort", 1'b1, 1'b1, 5, 3, -1, 10);
      run("ws_max", 1'b1, 1'b1, 15, -1, -1, 23);
      run("reidle", 1'b1, 1'b1, 0, -1, 3, 8);

      matchl = 1'b0;
      rw_i   = 1'b1;
      ws_i   = 4'd6;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      matchl = 1'b1;
      repeat (2) @(negedge clk);
      chk1("pre_rst_oel", oel, 1'b0);
      #2 resetl = 1'b0;
      #1;
      chk1("async_rst_csl", csl, 1'b1);
      chk1("async_rst_oel", oel, 1'b1);
      chk1("async_rst_busy", busy, 1'b0);
      chk1("async_rst_ack", ack, 1'b0);
      chk1("async_rst_csl3", csl3, 1'b1);
      @(negedge clk);
      resetl = 1'b1;
      @(negedge clk);
      run("post_rst", 1'b1, 1'b1, 2, -1, -1, 9);

      repeat (4) @(negedge clk);
      chkn("final_q_h1", q_a.size(), 0);
      chkn("final_q_h3", q_b.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
